// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer.
package shift_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        SH_LOG,
        SH_ARI,
        SH_ROT,
        SH_RCL
    } shift_mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/bshifter16.sv
// Single-step 16-bit shifter: one bit per call, fill bit i, ejected bit o.
module bshifter16 (
    input  logic [15:0] a,
    input  logic        ssl,
    input  logic        i,
    output logic [15:0] res,
    output logic        o
);

    assign res = ssl ? {a[14:0], i} : {i, a[15:1]};
    assign o   = ssl ? a[15] : a[0];

endmodule

// File: rtl/shift_seq16.sv
// Multi-bit shift/rotate sequencer, one bshifter16 step per clock.
module shift_seq16
    import shift_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_left,
    input  logic [1:0]       in_mode,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_carry,
    output logic             busy
);

    seq_state_t        state;
    shift_mode_t       mode_q;
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  cnt;
    logic              carry;
    logic              left_q;
    logic              fill;
    logic [DATA_W-1:0] step_res;
    logic              step_o;

    bshifter16 u_step (
        .a   (data),
        .ssl (left_q),
        .i   (fill),
        .res (step_res),
        .o   (step_o)
    );

    // Rotate fill comes from the data register, never from o.
    always_comb begin
        fill = 1'b0;
        unique case (mode_q)
            SH_LOG: fill = 1'b0;
            SH_ARI: fill = left_q ? 1'b0 : data[15];
            SH_ROT: fill = left_q ? data[15] : data[0];
            SH_RCL: fill = carry;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mode_q <= SH_LOG;
            data   <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            left_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data   <= in_data;
                        cnt    <= in_amt;
                        left_q <= in_left;
                        mode_q <= shift_mode_t'(in_mode);
                        carry  <= (in_mode == SH_RCL) ? in_cin : 1'b0;
                        state  <= (in_amt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data  <= step_res;
                    carry <= step_o;
                    cnt   <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_data  = data;
    assign out_carry = carry;

endmodule

// File: doc/shift_seq16.md
Name: shift_seq16

Overview:
- Multi-bit shift/rotate sequencer built around the existing 16-bit single-step shifter, bshifter16.
- Accepts one 16-bit operand, a shift amount of 0..15, a direction and a mode over a valid/ready handshake.
- Applies bshifter16 once per clock, selecting the fill bit each step, then presents the result and carry-out.
- Serves as a low-area shift unit for the starter-pack datapath, where a full log-depth barrel shifter is not wanted.

Parameters:
- AMT_W, 4, width of the shift-amount field; the maximum amount is 2^AMT_W-1 = 15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_data  in  16  operand.
- in_amt  in  AMT_W  shift count.
- in_left  in  1  1 = left shift, 0 = right shift; drives bshifter16 ssl.
- in_mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 rotate-through-carry.
- in_cin  in  1  initial carry, used only by mode 11.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  shifted result.
- out_carry  out  1  last bit shifted out (mode 11: the final carry).
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; data register, count and carry = 0.
  - in_ready = 1; out_valid = 0; out_data = 0; out_carry = 0; busy = 0.
- State IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch data, amt, left and mode.
  - Carry is loaded with in_cin if mode = 11, otherwise 0.
  - Go to SHIFT if amt != 0, else to DONE.
- State SHIFT:
  - Each cycle: data <= bshifter16.res, carry <= bshifter16.o, count <= count-1.
  - Leave to DONE on the cycle in which count goes 1 -> 0.
  - Fill bit i by mode and direction:
    - Logical: 0.
    - Arithmetic right: data[15]. Arithmetic left: 0, identical to logical.
    - Rotate left: data[15]. Rotate right: data[0]. Both come from the register, so there is no combinational loop through o.
    - Rotate-through-carry: the carry register, so 17-bit rotation semantics.
- State DONE:
  - out_valid = 1; out_data and out_carry hold the registered values.
  - Outputs stay stable until out_valid & out_ready, then return to IDLE.
  - in_ready is 0 throughout DONE, so no new request is accepted in the same cycle as the release.
- Latency:
  - Accept edge to out_valid = amt+1 cycles; amt = 0 gives 1 cycle.
  - Throughput is one request per amt+2 cycles when out_ready is held high.
- Boundary conditions:
  - amt = 0: out_data = in_data. out_carry = 0 for modes 00-10, in_cin for mode 11.
  - amt = 15: exactly 15 steps; count never wraps.
  - Request inputs are ignored outside IDLE; changes to in_* while busy have no effect.
  - out_ready asserted while out_valid = 0 is ignored.
  - Reset asserted mid-SHIFT or in DONE aborts the operation. The result is discarded and all outputs return to reset values immediately.
- Arithmetic: pure bit movement, no overflow flag. carry = bit ejected on the final step.

Decomposition:
- Shared package shift_pkg holds:
  - typedef enum logic[1:0] shift_mode_t {SH_LOG, SH_ARI, SH_ROT, SH_RCL}.
  - typedef enum logic[1:0] seq_state_t {S_IDLE, S_SHIFT, S_DONE}.
  - Constant DATA_W = 16.
- One sub-module instance: the existing bshifter16 as the single-step datapath.
- The fill-bit mux and the FSM stay in shift_seq16.

Test Plan:
1. Logical left: in_data=16'h0001, amt=4, left=1, mode=00 -> out_data=16'h0010, out_carry=0, out_valid exactly 5 cycles after accept.
2. Arithmetic right: in_data=16'h8004, amt=3, left=0, mode=01 -> out_data=16'hF000, out_carry=1.
3. Rotate right: in_data=16'h1234, amt=4, left=0, mode=10 -> out_data=16'h4123, out_carry=0. Rotate left: 16'h8001, amt=15 -> 16'hC000, out_carry=0.
4. Rotate-through-carry left: in_data=16'h8000, cin=0, amt=1, mode=11 -> out_data=16'h0000, carry=1. Repeat with in_data=16'h0000, cin=1, amt=1 -> out_data=16'h0001, carry=0.
5. Handshake:
   - amt=0 -> out_valid one cycle after accept with in_data unchanged.
   - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, new in_valid ignored.
   - out_ready=1 -> IDLE next cycle with in_ready=1.
6. Reset mid-op: start amt=10 and drop rst_n at step 5 -> out_valid=0, out_data=0 and busy=0 immediately. After release, a fresh request completes correctly.
